// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core's Memory-Access stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-strobed stores, a programmable number of
// wait states and a single outstanding request over valid/ready handshakes.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        capture;
    logic        access;
    logic        in_range;
    logic        mem_we;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic [AW-1:0] acc_idx;

    logic [31:0] mem_q [DEPTH];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        capture   = 1'b0;
        access    = 1'b0;
        acc_wr    = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the access uses the request as it arrives.
                        access    = 1'b1;
                        acc_wr    = bus.req_write;
                        acc_addr  = bus.req_addr;
                        acc_wdata = bus.req_wdata;
                        acc_wstrb = bus.req_wstrb;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Full 32-bit range check so high addresses never alias into the array.
        in_range = (acc_addr < 32'(DEPTH));
        acc_idx  = acc_addr[AW-1:0];
        if (access) begin
            err_d   = !in_range;
            rdata_d = (!acc_wr && in_range) ? mem_q[acc_idx] : 32'd0;
        end
        mem_we = access && acc_wr && in_range && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
        end
    end

    // Array contents survive reset; only completed stores change them.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[acc_idx] <= merge_bytes(mem_q[acc_idx], acc_wdata, acc_wstrb);
    end

    assign bus.req_ready  = (state_q == IDLE) && reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance driven
// with directed requests; monitors pop expected responses on each handshake.
module tb_dmem_responder;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    exp_t qa[$];
    exp_t qb[$];

    int   acc_a = 0;
    int   acc_b = 0;
    int   prev_acc_b = -1;
    logic a_prev_vld = 1'b0;
    logic b_prev_vld = 1'b0;

    logic [31:0] b_data [4];

    dmem_responder_if a ();
    dmem_responder_if b ();

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (a)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor for the WAIT_CYCLES=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (a.req_valid && a.req_ready) acc_a = cyc + 1;
        if (a.resp_valid && !a_prev_vld) chk("a_latency", 32'(cyc - acc_a + 1), 32'd3);
        a_prev_vld = a.resp_valid;
        if (a.resp_valid && a.resp_ready) begin
            if (qa.size() == 0) begin
                fail_now("a_unexpected_resp");
            end else begin
                e = qa.pop_front();
                chk("a_rdata", a.resp_rdata, e.rdata);
                chk1("a_err", a.resp_err, e.err);
            end
        end
    end

    // Monitor for the WAIT_CYCLES=0 instance.
    always @(negedge clk) begin
        exp_t e;
        if (b.req_valid && b.req_ready) begin
            acc_b = cyc + 1;
            if (prev_acc_b >= 0) chk("b_accept_spacing", 32'(acc_b - prev_acc_b), 32'd2);
            prev_acc_b = acc_b;
        end
        if (b.resp_valid && !b_prev_vld) chk("b_latency", 32'(cyc - acc_b + 1), 32'd1);
        b_prev_vld = b.resp_valid;
        if (b.resp_valid && b.resp_ready) begin
            if (qb.size() == 0) begin
                fail_now("b_unexpected_resp");
            end else begin
                e = qb.pop_front();
                chk("b_rdata", b.resp_rdata, e.rdata);
                chk1("b_err", b.resp_err, e.err);
            end
        end
    end

    task automatic a_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic push,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        if (push) qa.push_back(exp_t'{exp_rdata, exp_err});
        a.req_write = wr;
        a.req_addr  = addr;
        a.req_wdata = wdata;
        a.req_wstrb = strb;
        a.req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a.req_ready && n < 50);
        if (!a.req_ready) fail_now("a_accept");
        @(posedge clk);
        #1;
        a.req_valid = 1'b0;
    endtask

    task automatic a_drain();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (qa.size() != 0) begin
            fail_now("a_drain");
            qa.delete();
        end
    endtask

    task automatic b_drain();
        int n;
        n = 0;
        while (qb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (qb.size() != 0) begin
            fail_now("b_drain");
            qb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b_data[0] = 32'h0123_4567;
        b_data[1] = 32'h89AB_CDEF;
        b_data[2] = 32'hCAFE_F00D;
        b_data[3] = 32'h0000_FFFF;

        a.req_valid = 1'b0; a.req_write = 1'b0; a.req_addr = '0;
        a.req_wdata = '0;   a.req_wstrb = '0;   a.resp_ready = 1'b1;
        b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0;
        b.req_wdata = '0;   b.req_wstrb = '0;   b.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_a_resp_valid", a.resp_valid, 1'b0);
        chk ("rst_a_resp_rdata", a.resp_rdata, 32'd0);
        chk1("rst_a_resp_err",   a.resp_err,   1'b0);
        chk1("rst_a_req_ready",  a.req_ready,  1'b0);
        chk1("rst_b_resp_valid", b.resp_valid, 1'b0);
        chk ("rst_b_resp_rdata", b.resp_rdata, 32'd0);
        chk1("rst_b_req_ready",  b.req_ready,  1'b0);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_a_req_ready", a.req_ready, 1'b1);
        chk1("post_rst_b_req_ready", b.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Reference word at address 0 for the aliasing check later.
        a_req(1'b1, 32'd0, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'd0, 1'b0); a_drain();

        // Store then load.
        a_req(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'd0, 1'b0); a_drain();
        a_req(1'b0, 32'd5, 32'd0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0); a_drain();

        // Single-lane store to byte 1.
        a_req(1'b1, 32'd5, 32'h0000_1200, 4'h2, 1'b1, 32'd0, 1'b0); a_drain();
        a_req(1'b0, 32'd5, 32'd0, 4'h0, 1'b1, 32'hDEAD_12EF, 1'b0); a_drain();

        // Zero-strobe store is a no-op that still responds.
        a_req(1'b1, 32'd5, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'd0, 1'b0); a_drain();

        // Backpressure with a second request waiting.
        a.resp_ready = 1'b0;
        a_req(1'b0, 32'd5, 32'd0, 4'h0, 1'b1, 32'hDEAD_12EF, 1'b0);
        qa.push_back(exp_t'{32'hA5A5_A5A5, 1'b0});
        a.req_write = 1'b0;
        a.req_addr  = 32'd0;
        a.req_valid = 1'b1;
        n = 0;
        while (!a.resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!a.resp_valid) fail_now("bp_resp_valid");
        for (int i = 0; i < 5; i++) begin
            chk1("bp_resp_valid_held", a.resp_valid, 1'b1);
            chk ("bp_rdata_held",      a.resp_rdata, 32'hDEAD_12EF);
            chk1("bp_req_ready_low",   a.req_ready,  1'b0);
            @(posedge clk);
            #1;
        end
        a.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("bp_req_ready_after_hs",  a.req_ready,  1'b1);
        chk1("bp_resp_valid_after_hs", a.resp_valid, 1'b0);
        @(posedge clk);
        #1;
        chk1("bp_second_accepted", a.req_ready, 1'b0);
        a.req_valid = 1'b0;
        a_drain();

        // Out of range, including a high address whose low bits alias 0.
        a_req(1'b0, 32'd256, 32'd0, 4'h0, 1'b1, 32'd0, 1'b1); a_drain();
        a_req(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 1'b1); a_drain();
        a_req(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'hA5A5_A5A5, 1'b0); a_drain();

        // Zero-wait instance: 4 stores then 4 loads, request held back to back.
        for (int k = 0; k < 8; k++) begin
            b.req_write = (k < 4);
            b.req_addr  = 32'(k % 4);
            b.req_wdata = b_data[k % 4];
            b.req_wstrb = 4'hF;
            b.req_valid = 1'b1;
            qb.push_back(exp_t'{(k < 4) ? 32'd0 : b_data[k % 4], 1'b0});
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!b.req_ready && n < 20);
            if (!b.req_ready) fail_now("b_accept");
            @(posedge clk);
            #1;
        end
        b.req_valid = 1'b0;
        b_drain();

        // Reset during WAIT discards the pending store.
        a_req(1'b1, 32'd7, 32'h1111_1111, 4'hF, 1'b1, 32'd0, 1'b0); a_drain();
        a_req(1'b1, 32'd7, 32'h2222_2222, 4'hF, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("midrst_resp_valid", a.resp_valid, 1'b0);
        chk1("midrst_req_ready",  a.req_ready,  1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk1("midrst_resp_valid_hold", a.resp_valid, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        chk1("midrst_idle_req_ready", a.req_ready,  1'b1);
        chk1("midrst_idle_resp_valid", a.resp_valid, 1'b0);
        @(posedge clk);
        #1;
        a_req(1'b0, 32'd7, 32'd0, 4'h0, 1'b1, 32'h1111_1111, 1'b0); a_drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
